// File: rtl/param_accumulator.sv
// param_accumulator: sums TERMS operands of SIZE bits per batch, with a sticky
// overflow flag and a valid/ready handshake on both the operand and the result.
// Optional build macro: ACCUM_SATURATE_EN clamps acc to all-ones once a batch
// overflows; without it acc wraps modulo 2^SIZE.
//
// state | meaning
// IDLE  | waiting for start; last batch result still visible on acc/carry
// ACC   | accepting operands until TERMS beats have been summed
// DONE  | result presented with out_valid until out_ready is seen
module param_accumulator #(
    parameter int SIZE  = 4,
    parameter int TERMS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            in_valid,
    input  logic [SIZE-1:0] in_data,
    output logic            in_ready,
    output logic [SIZE-1:0] acc,
    output logic            carry,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy
);

    // Wide enough to hold TERMS itself, so the count never wraps in a batch.
    localparam int CW = $clog2(TERMS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;
    logic          beat;
    logic          last_beat;
    logic [SIZE:0] sum_ext;

    assign beat      = (state == ACC) && in_valid;
    assign last_beat = beat && (count == CW'(TERMS - 1));
    assign sum_ext   = {1'b0, acc} + {1'b0, in_data};

    // Handshake and status outputs are pure decodes of the state register.
    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; start only matters in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = ACC;
            ACC:     if (last_beat) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Accumulator, sticky carry and beat count; cleared on start, updated per accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
        end else if ((state == IDLE) && start) begin
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
        end else if (beat) begin
            count <= count + CW'(1);
            carry <= carry | sum_ext[SIZE];
`ifdef ACCUM_SATURATE_EN
            acc   <= (carry | sum_ext[SIZE]) ? '1 : sum_ext[SIZE-1:0];
`else
            acc   <= sum_ext[SIZE-1:0];
`endif
        end
    end

endmodule

// File: tb/tb_param_accumulator.sv
// Bench for param_accumulator (SIZE=2, TERMS=4): directed scenarios followed by
// random batches, all checked against an integer-sum reference model.
module tb_param_accumulator;

    localparam int SIZE  = 2;
    localparam int TERMS = 4;
    localparam int MAXV  = 1 << SIZE;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic            in_valid = 1'b0;
    logic [SIZE-1:0] in_data = '0;
    logic            out_ready = 1'b0;
    logic            in_ready;
    logic [SIZE-1:0] acc;
    logic            carry;
    logic            out_valid;
    logic            busy;

    int n_vec = 0;
    int n_err = 0;
    int total = 0;
    int beats = 0;

    param_accumulator #(.SIZE(SIZE), .TERMS(TERMS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .acc       (acc),
        .carry     (carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: the batch result is the true integer sum of the operands,
    // reduced modulo 2^SIZE (or clamped when saturating); carry means the
    // true sum ever reached 2^SIZE.
    function automatic int exp_acc();
`ifdef ACCUM_SATURATE_EN
        return (total >= MAXV) ? MAXV - 1 : total % MAXV;
`else
        return total % MAXV;
`endif
    endfunction

    function automatic int exp_carry();
        return (total >= MAXV) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start    = 1'b1;
        in_valid = 1'($urandom_range(0, 1));
        in_data  = SIZE'($urandom);
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        total    = 0;
        beats    = 0;
        chk("start_busy",     busy,     1);
        chk("start_in_ready", in_ready, 1);
        chk("start_acc",      acc,      0);
        chk("start_carry",    carry,    0);
    endtask

    task automatic send_beat(input int d);
        in_valid = 1'b1;
        in_data  = SIZE'(d);
        start    = 1'($urandom_range(0, 1));
        tick();
        in_valid = 1'b0;
        start    = 1'b0;
        total   += d;
        beats++;
        chk("beat_acc",   acc,   exp_acc());
        chk("beat_carry", carry, exp_carry());
        if (beats == TERMS) begin
            chk("last_out_valid", out_valid, 1);
            chk("last_in_ready",  in_ready,  0);
        end else begin
            chk("mid_out_valid", out_valid, 0);
            chk("mid_in_ready",  in_ready,  1);
        end
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in_data  = SIZE'($urandom);
            start    = 1'($urandom_range(0, 1));
            tick();
            chk("gap_acc",      acc,      exp_acc());
            chk("gap_carry",    carry,    exp_carry());
            chk("gap_in_ready", in_ready, 1);
        end
        start = 1'b0;
    endtask

    task automatic drain(input int hold);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = SIZE'($urandom);
            start     = 1'($urandom_range(0, 1));
            tick();
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready",  in_ready,  0);
            chk("hold_busy",      busy,      1);
            chk("hold_acc",       acc,       exp_acc());
            chk("hold_carry",     carry,     exp_carry());
        end
        out_ready = 1'b1;
        start     = 1'b1;
        in_valid  = 1'b1;
        in_data   = SIZE'($urandom);
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        chk("exit_out_valid", out_valid, 0);
        chk("exit_busy",      busy,      0);
        chk("exit_in_ready",  in_ready,  0);
        chk("exit_acc",       acc,       exp_acc());
        chk("exit_carry",     carry,     exp_carry());
        tick();
        chk("idle_busy",      busy,      0);
        chk("idle_acc",       acc,       exp_acc());
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_acc"},       acc,       0);
        chk({tag, "_carry"},     carry,     0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_in_ready"},  in_ready,  0);
        chk({tag, "_busy"},      busy,      0);
    endtask

    initial begin
        // Asynchronous reset, asserted away from any clock edge.
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_state("por");
        for (int i = 0; i < 3; i++) begin
            start     = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = SIZE'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            tick();
            chk_reset_state("rst_hold");
        end
        #3;
        rst_n     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        chk_reset_state("post_rst");

        // Back-to-back beats, no overflow.
        do_start();
        send_beat(1); send_beat(0); send_beat(1); send_beat(0);
        chk("b2b_acc", acc, 2);
        drain(0);

        // Overflow batch, held in DONE for five cycles with junk input.
        do_start();
        send_beat(3); send_beat(3); send_beat(0); send_beat(0);
        chk("ovf_carry", carry, 1);
        drain(5);

        // Gaps with start pulsed mid-batch.
        do_start();
        send_beat(1);
        gap(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("midstart_acc", acc, exp_acc());
        chk("midstart_busy", busy, 1);
        gap(1);
        send_beat(1); send_beat(1); send_beat(0);
        chk("gaps_acc",   acc,   3);
        chk("gaps_carry", carry, 0);
        drain(1);

        // Reset mid-batch discards the partial sum.
        do_start();
        send_beat(3); send_beat(1);
        #3;
        rst_n = 1'b0;
        #1;
        total = 0;
        beats = 0;
        chk_reset_state("midrst");
        #2;
        rst_n = 1'b1;
        tick();
        chk("after_midrst_busy", busy, 0);
        do_start();
        send_beat(1); send_beat(1); send_beat(1); send_beat(0);
        chk("newbatch_acc",   acc,   3);
        chk("newbatch_carry", carry, 0);
        drain(0);

        // Random batches.
        for (int b = 0; b < 30; b++) begin
            do_start();
            for (int k = 0; k < TERMS; k++) begin
                gap($urandom_range(0, 2));
                send_beat($urandom_range(0, MAXV - 1));
            end
            drain($urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
